// File: rtl/dcc_pkg.sv
// Shared types and defaults for the DCC clock-enable controller.
package dcc_pkg;

    typedef enum logic [1:0] {
        OFF        = 2'd0,
        ON_SETTLE  = 2'd1,
        ON         = 2'd2,
        OFF_SETTLE = 2'd3
    } dcc_state_e;

    localparam int DCC_SETTLE_DEFAULT = 8;
    localparam int DCC_SYNC_DEFAULT   = 2;
    localparam int DCC_SETTLE_W       = 8;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop level synchroniser for asynchronous control inputs.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/dcc_ce_ctrl.sv
// CE driver for a DCC gate: synchronised request, minimum-dwell CE edges,
// settled acknowledge and a saturating gate-off event counter.
module dcc_ce_ctrl
    import dcc_pkg::*;
#(
    parameter int SYNC_STAGES   = DCC_SYNC_DEFAULT,
    parameter int SETTLE_CYCLES = DCC_SETTLE_DEFAULT,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_req,
    input  logic             dccen_cfg,
    output logic             ce_o,
    output logic             ack_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] off_cnt_o,
    input  logic             cnt_clr
);

    localparam logic [DCC_SETTLE_W-1:0] SETTLE_LOAD = DCC_SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]        CNT_MAX     = '1;

    dcc_state_e              state;
    logic [DCC_SETTLE_W-1:0] settle_cnt;
    logic                    req_s;
    logic                    off_done;

    sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (en_req),
        .q     (req_s)
    );

    // dccen_cfg low overrides everything: the DCC is treated as permanently open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= OFF;
            ce_o       <= 1'b0;
            ack_o      <= 1'b0;
            busy_o     <= 1'b0;
            settle_cnt <= '0;
        end else if (!dccen_cfg) begin
            state      <= ON;
            ce_o       <= 1'b1;
            ack_o      <= 1'b1;
            busy_o     <= 1'b0;
            settle_cnt <= '0;
        end else begin
            case (state)
                OFF: begin
                    if (req_s) begin
                        state      <= ON_SETTLE;
                        ce_o       <= 1'b1;
                        busy_o     <= 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                ON_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state  <= ON;
                        ack_o  <= 1'b1;
                        busy_o <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ON: begin
                    if (!req_s) begin
                        state      <= OFF_SETTLE;
                        ce_o       <= 1'b0;
                        busy_o     <= 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                OFF_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state  <= OFF;
                        ack_o  <= 1'b0;
                        busy_o <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= OFF;
                end
            endcase
        end
    end

    // A bypass that lands on the final settle cycle aborts the gate-off, so it is not counted.
    assign off_done = dccen_cfg && (state == OFF_SETTLE) && (settle_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_cnt_o <= '0;
        end else if (cnt_clr) begin
            off_cnt_o <= '0;
        end else if (off_done && (off_cnt_o != CNT_MAX)) begin
            off_cnt_o <= off_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_dcc_ce_ctrl.sv
// Randomised scoreboard bench for dcc_ce_ctrl against a dwell-timing reference model.
module tb_dcc_ce_ctrl;

    localparam int SYNC   = 2;
    localparam int SETTLE = 8;
    localparam int CW     = 4;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en_req;
    logic          dccen_cfg;
    logic          cnt_clr;
    logic          ce_o;
    logic          ack_o;
    logic          busy_o;
    logic [CW-1:0] off_cnt_o;

    dcc_ce_ctrl #(
        .SYNC_STAGES   (SYNC),
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_req    (en_req),
        .dccen_cfg (dccen_cfg),
        .ce_o      (ce_o),
        .ack_o     (ack_o),
        .busy_o    (busy_o),
        .off_cnt_o (off_cnt_o),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    // Gate modelled as a level plus the age of its last edge; settled once age reaches SETTLE.
    typedef struct {
        bit            ce;
        bit            ack;
        bit            busy;
        bit            settled;
        bit            off_done;
        int            age;
        int            cnt;
        bit [SYNC-1:0] hist;
    } mdl_t;

    typedef struct packed {
        logic          ce;
        logic          ack;
        logic          busy;
        logic [CW-1:0] cnt;
    } exp_t;

    mdl_t m;
    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic mdl_t mreset();
        mdl_t r;
        r.ce = 0; r.ack = 0; r.busy = 0; r.settled = 1; r.off_done = 0;
        r.age = 0; r.cnt = 0; r.hist = '0;
        return r;
    endfunction

    function automatic mdl_t mstep(input mdl_t c, input bit req, input bit dcc, input bit clr);
        mdl_t n;
        bit   req_s;
        n          = c;
        n.off_done = 0;
        req_s      = c.hist[SYNC-1];
        n.hist     = {c.hist[SYNC-2:0], req};
        if (!dcc) begin
            n.ce = 1; n.ack = 1; n.busy = 0; n.settled = 1;
        end else if (c.settled) begin
            if (req_s != c.ce) begin
                n.ce = req_s; n.age = 0; n.busy = 1; n.settled = 0;
            end
        end else begin
            n.age = c.age + 1;
            if (n.age >= SETTLE) begin
                n.settled = 1; n.busy = 0; n.ack = c.ce;
                if (!c.ce) begin
                    n.off_done = 1;
                    if (n.cnt < CMAX) n.cnt = n.cnt + 1;
                end
            end
        end
        if (clr) n.cnt = 0;
        return n;
    endfunction

    task automatic cyc(input bit req, input bit dcc, input bit clr);
        exp_t e;
        @(negedge clk);
        rst_n     = 1'b1;
        en_req    = req;
        dccen_cfg = dcc;
        cnt_clr   = clr;
        m         = mstep(m, req, dcc, clr);
        e.ce      = m.ce;
        e.ack     = m.ack;
        e.busy    = m.busy;
        e.cnt     = m.cnt[CW-1:0];
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        m = mreset();
    endtask

    // Monitor: pops one expectation per clocked cycle; also checks reset values on reset entry.
    exp_t            e_mon;
    logic [CW+2:0]   got;
    int              gap      = 1000;
    bit              byp      = 0;
    logic            prev_ce  = 1'b0;
    logic            last_rst = 1'b1;

    always begin
        @(posedge clk or negedge rst_n);
        #1;
        got = {ce_o, ack_o, busy_o, off_cnt_o};
        if (!rst_n) begin
            if (last_rst) begin
                n_chk++;
                if (got !== '0) begin
                    n_fail++;
                    $display("FAIL reset_state t=%0t got ce=%b ack=%b busy=%b cnt=%0d want all zero",
                             $time, ce_o, ack_o, busy_o, off_cnt_o);
                end
            end
            prev_ce = 1'b0;
            gap     = 1000;
            byp     = 0;
        end else if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            n_chk++;
            if (got !== e_mon) begin
                n_fail++;
                $display("FAIL outputs t=%0t got ce=%b ack=%b busy=%b cnt=%0d want ce=%b ack=%b busy=%b cnt=%0d",
                         $time, ce_o, ack_o, busy_o, off_cnt_o, e_mon.ce, e_mon.ack, e_mon.busy, e_mon.cnt);
            end
            gap++;
            if (!dccen_cfg) byp = 1;
            if (ce_o !== prev_ce) begin
                if (!byp) begin
                    n_chk++;
                    if (gap < SETTLE) begin
                        n_fail++;
                        $display("FAIL ce_spacing t=%0t got gap=%0d want >=%0d", $time, gap, SETTLE);
                    end
                end
                gap     = 0;
                byp     = !dccen_cfg;
                prev_ce = ce_o;
            end
        end
        last_rst = rst_n;
    end

    int  hold_req;
    int  hold_byp;
    bit  rq;
    bit  clr;
    mdl_t t;

    initial begin
        rst_n     = 1'b0;
        en_req    = 1'b0;
        dccen_cfg = 1'b1;
        cnt_clr   = 1'b0;
        m         = mreset();
        repeat (3) @(negedge clk);

        // Basic cycle: 40-cycle request then idle
        repeat (40) cyc(1, 1, 0);
        repeat (30) cyc(0, 1, 0);

        // Single-cycle pulse
        cyc(1, 1, 0);
        repeat (35) cyc(0, 1, 0);

        // Request withdrawn shortly after ce rises
        repeat (4) cyc(1, 1, 0);
        repeat (35) cyc(0, 1, 0);

        // Async reset in the middle of the on-settle, request held through release
        repeat (6) cyc(1, 1, 0);
        do_reset(2);
        repeat (20) cyc(1, 1, 0);

        // Bypass asserted during the off-settle, en_req toggling under bypass
        repeat (6) cyc(0, 1, 0);
        for (int k = 0; k < 10; k++) cyc(k[0], 0, 0);
        repeat (30) cyc(0, 1, 0);

        // Counter saturation, then clear coincident with the final gate-off
        cyc(0, 1, 1);
        for (int p = 0; p < 17; p++) begin
            cyc(1, 1, 0);
            for (int k = 0; k < 26; k++) begin
                clr = 0;
                if (p == 16) begin
                    t   = mstep(m, 0, 1, 0);
                    clr = t.off_done;
                end
                cyc(0, 1, clr);
            end
        end

        // Random traffic
        hold_req = 0;
        hold_byp = 0;
        rq       = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold_req == 0) begin
                rq       = bit'($urandom_range(0, 1));
                hold_req = $urandom_range(1, 30);
            end
            hold_req--;
            if (hold_byp > 0) hold_byp--;
            else if ($urandom_range(0, 59) == 0) hold_byp = $urandom_range(1, 8);
            if ($urandom_range(0, 399) == 0) do_reset(2);
            cyc(rq, hold_byp == 0, $urandom_range(0, 99) == 0);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
